// File: rtl/pwm_button_conditioner.sv
// Button conditioner ahead of the PWM duty register: synchronise, debounce, emit one-clk inc/dec pulses.
// Build option AUTO_REPEAT_EN adds press-and-hold auto-repeat; without it each debounced press gives one pulse.

module pwm_btn_channel #(
  parameter int DEBOUNCE_TICKS = 3
`ifdef AUTO_REPEAT_EN
  ,
  parameter int REPEAT_DELAY = 8,
  parameter int REPEAT_RATE  = 2
`endif
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  input  logic tick,
  input  logic btn,
  output logic level,
  output logic evt
);
  // state  | meaning
  // IDLE   | button released, or block disabled; waiting for a debounced press
  // DELAY  | pressed; counting ticks up to the first auto-repeat (AUTO_REPEAT_EN)
  // REPEAT | held past the delay; an event every REPEAT_RATE ticks (AUTO_REPEAT_EN)
  // HELD   | pressed and already reported; waits for release (no auto-repeat)

  localparam int DB_W = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_TICKS - 1);

  logic            sync_a;
  logic            sync_b;
  logic [DB_W-1:0] db_cnt;
  logic            level_q;
  logic            rise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_a <= 1'b0;
      sync_b <= 1'b0;
    end else begin
      sync_a <= btn;
      sync_b <= sync_a;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level  <= 1'b0;
      db_cnt <= '0;
    end else if (tick) begin
      if (sync_b != level) begin
        if (db_cnt == DB_LAST) begin
          level  <= ~level;
          db_cnt <= '0;
        end else begin
          db_cnt <= db_cnt + 1'b1;
        end
      end else begin
        db_cnt <= '0;
      end
    end
  end

  // Gating with ena makes a still-held button look like a fresh press once ena returns.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) level_q <= 1'b0;
    else        level_q <= level & ena;
  end

  assign rise = level & ~level_q;

`ifdef AUTO_REPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);
  localparam logic [RPT_W-1:0] DELAY_LAST = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] RATE_LAST  = RPT_W'(REPEAT_RATE - 1);

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;
  state_t           state;
  logic [RPT_W-1:0] rpt_cnt;

  always_comb begin
    evt = 1'b0;
    if (ena && level) begin
      case (state)
        IDLE:    evt = rise;
        DELAY:   evt = tick && (rpt_cnt == DELAY_LAST);
        REPEAT:  evt = tick && (rpt_cnt == RATE_LAST);
        default: evt = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      rpt_cnt <= '0;
    end else if (!ena || !level) begin
      state   <= IDLE;
      rpt_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (rise) begin
            state   <= DELAY;
            rpt_cnt <= '0;
          end
        end
        DELAY: begin
          if (evt) begin
            state   <= REPEAT;
            rpt_cnt <= '0;
          end else if (tick) begin
            rpt_cnt <= rpt_cnt + 1'b1;
          end
        end
        REPEAT: begin
          if (evt)       rpt_cnt <= '0;
          else if (tick) rpt_cnt <= rpt_cnt + 1'b1;
        end
        default: begin
          state   <= IDLE;
          rpt_cnt <= '0;
        end
      endcase
    end
  end
`else
  typedef enum logic {IDLE, HELD} state_t;
  state_t state;

  assign evt = ena && level && (state == IDLE) && rise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               state <= IDLE;
    else if (!ena || !level)  state <= IDLE;
    else if (rise)            state <= HELD;
  end
`endif

endmodule

module pwm_button_conditioner #(
  parameter int TICK_DIV       = 4,
  parameter int DEBOUNCE_TICKS = 3,
  parameter int REPEAT_DELAY   = 8,
  parameter int REPEAT_RATE    = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  input  logic inc_btn_i,
  input  logic dec_btn_i,
  output logic inc_pulse_o,
  output logic dec_pulse_o,
  output logic inc_level_o,
  output logic dec_level_o,
  output logic tick_o
);
  localparam int TICK_W = $clog2(TICK_DIV);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

  logic [TICK_W-1:0] tick_cnt;
  logic              tick;
  logic              inc_evt;
  logic              dec_evt;

  if (TICK_DIV < 2 || DEBOUNCE_TICKS < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_param_check
    $error("pwm_button_conditioner: parameter out of range");
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                            tick_cnt <= '0;
    else if (!ena || tick_cnt == TICK_LAST) tick_cnt <= '0;
    else                                   tick_cnt <= tick_cnt + 1'b1;
  end

  assign tick   = ena && (tick_cnt == TICK_LAST);
  assign tick_o = tick;

  pwm_btn_channel #(
    .DEBOUNCE_TICKS(DEBOUNCE_TICKS)
`ifdef AUTO_REPEAT_EN
    ,
    .REPEAT_DELAY(REPEAT_DELAY),
    .REPEAT_RATE(REPEAT_RATE)
`endif
  ) u_inc (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .tick  (tick),
    .btn   (inc_btn_i),
    .level (inc_level_o),
    .evt   (inc_evt)
  );

  pwm_btn_channel #(
    .DEBOUNCE_TICKS(DEBOUNCE_TICKS)
`ifdef AUTO_REPEAT_EN
    ,
    .REPEAT_DELAY(REPEAT_DELAY),
    .REPEAT_RATE(REPEAT_RATE)
`endif
  ) u_dec (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .tick  (tick),
    .btn   (dec_btn_i),
    .level (dec_level_o),
    .evt   (dec_evt)
  );

  // Each command is suppressed while the opposite button is debounced-pressed, so pulses never coincide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inc_pulse_o <= 1'b0;
      dec_pulse_o <= 1'b0;
    end else begin
      inc_pulse_o <= inc_evt & ~dec_level_o;
      dec_pulse_o <= dec_evt & ~inc_level_o;
    end
  end

endmodule
